// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence-display engine: FSM state codes used by
// db_estado and by the control unit's debug decoder.
package exibe_sequencia_pkg;

    localparam logic [3:0] EST_INICIAL = 4'd0;
    localparam logic [3:0] EST_PREPARA = 4'd1;
    localparam logic [3:0] EST_CARREGA = 4'd2;
    localparam logic [3:0] EST_ACESO   = 4'd3;
    localparam logic [3:0] EST_APAGADO = 4'd4;
    localparam logic [3:0] EST_FIM     = 4'd5;

    typedef enum logic [3:0] {
        INICIAL = EST_INICIAL,
        PREPARA = EST_PREPARA,
        CARREGA = EST_CARREGA,
        ACESO   = EST_ACESO,
        APAGADO = EST_APAGADO,
        FIM     = EST_FIM
    } estado_t;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int largura_contador(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/temporizador_exibicao.sv
// Modulo-N counter with synchronous clear and enable. The terminal value
// (N-1) is an input so one instance serves both the on-time and the gap.
module temporizador_exibicao #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               conta,
    input  logic [LARGURA-1:0] ultimo,
    output logic               fim
);

    logic [LARGURA-1:0] valor;

    // Count while enabled, wrapping to zero after the terminal value.
    always_ff @(posedge clock) begin
        if (reset || limpa)
            valor <= '0;
        else if (conta)
            valor <= (valor == ultimo) ? '0 : valor + LARGURA'(1);
    end

    assign fim = (valor == ultimo);

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence-display engine: walks ROM addresses 0..lim_r, showing each value
// on the LEDs for TEMPO_ACESO cycles followed by TEMPO_APAGADO blank cycles.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int TEMPO_ACESO   = 50_000_000,
    parameter int TEMPO_APAGADO = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado_rom,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int T_MAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
    localparam int TW    = largura_contador(T_MAX);
    localparam logic [TW-1:0] ULT_ACESO   = TW'(TEMPO_ACESO - 1);
    localparam logic [TW-1:0] ULT_APAGADO = TW'(TEMPO_APAGADO - 1);

    estado_t    estado, prox;
    logic [3:0] lim_r;
    logic       carrega_lim, zera_end, inc_end, carrega_leds, zera_leds;
    logic       limpa_tmr, conta_tmr, fim_tmr;
    logic [TW-1:0] ultimo_tmr;

    // The timer's terminal value follows the phase being timed.
    assign ultimo_tmr = (estado == ACESO) ? ULT_ACESO : ULT_APAGADO;

    temporizador_exibicao #(.LARGURA(TW)) u_tmr (
        .clock  (clock),
        .reset  (reset),
        .limpa  (limpa_tmr),
        .conta  (conta_tmr),
        .ultimo (ultimo_tmr),
        .fim    (fim_tmr)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            estado <= INICIAL;
        else
            estado <= prox;
    end

    // Next-state and datapath control decoding.
    always_comb begin
        prox         = estado;
        carrega_lim  = 1'b0;
        zera_end     = 1'b0;
        inc_end      = 1'b0;
        carrega_leds = 1'b0;
        zera_leds    = 1'b0;
        limpa_tmr    = 1'b0;
        conta_tmr    = 1'b0;
        case (estado)
            INICIAL: begin
                if (iniciar) begin
                    carrega_lim = 1'b1;
                    zera_end    = 1'b1;
                    prox        = PREPARA;
                end
            end
            PREPARA: prox = CARREGA;   // ROM address-to-data latency
            CARREGA: begin
                carrega_leds = 1'b1;
                limpa_tmr    = 1'b1;
                prox         = ACESO;
            end
            ACESO: begin
                conta_tmr = 1'b1;
                if (fim_tmr) begin
                    zera_leds = 1'b1;
                    limpa_tmr = 1'b1;
                    prox      = APAGADO;
                end
            end
            APAGADO: begin
                conta_tmr = 1'b1;
                if (fim_tmr) begin
                    limpa_tmr = 1'b1;
                    if (endereco == lim_r) begin
                        prox = FIM;
                    end else begin
                        inc_end = 1'b1;
                        prox    = PREPARA;
                    end
                end
            end
            FIM:     prox = INICIAL;
            default: prox = INICIAL;
        endcase
    end

    // Address counter, round limit and LED register; the address is never
    // incremented past lim_r, so it cannot wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco <= 4'd0;
            lim_r    <= 4'd0;
            leds     <= 4'd0;
        end else begin
            if (carrega_lim)  lim_r    <= limite;
            if (zera_end)     endereco <= 4'd0;
            else if (inc_end) endereco <= endereco + 4'd1;
            if (carrega_leds) leds     <= dado_rom;
            else if (zera_leds) leds   <= 4'd0;
        end
    end

    assign ocupado   = (estado != INICIAL);
    assign pronto    = (estado == FIM);
    assign db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia with short timings (4 on, 2 off) and a 1-cycle
// synchronous ROM model. Expected outputs come from cycle offset arithmetic.
module tb_exibe_sequencia;

    localparam int TA   = 4;
    localparam int TP   = 2;
    localparam int ITEM = 2 + TA + TP;

    logic       clock = 1'b0;
    logic       reset, iniciar, ocupado, pronto;
    logic [3:0] limite, dado_rom, endereco, leds, db_estado;
    logic [3:0] rom [16];
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    // Synchronous ROM: data for an address is valid one cycle later.
    always @(posedge clock) dado_rom <= rom[endereco];

    exibe_sequencia #(.TEMPO_ACESO(TA), .TEMPO_APAGADO(TP)) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .limite   (limite),
        .dado_rom (dado_rom),
        .endereco (endereco),
        .leds     (leds),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .db_estado(db_estado)
    );

    task automatic load_rom_random();
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; iniciar = 1'b1; limite = 4'd5;
        repeat (2) @(negedge clock);
        checks++;
        if ({db_estado, endereco, leds, ocupado, pronto} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got st=%0d end=%0d leds=%0h ocup=%0b pronto=%0b exp all 0",
                     db_estado, endereco, leds, ocupado, pronto);
        end
        reset = 1'b0; iniciar = 1'b0;
        @(negedge clock);
        checks++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got st=%0d ocup=%0b exp st=0 ocup=0", db_estado, ocupado);
        end
    endtask

    // Starts a run at the next negedge (must be INICIAL) and checks every
    // cycle up to the pronto pulse. perturb pulses iniciar and changes limite
    // mid-run; both must be ignored.
    task automatic run_sequence(input int lim, input bit perturb);
        int kfim, it, ph;
        logic [3:0] e_st, e_leds, e_end;
        logic e_pr;
        kfim = 1 + (lim + 1) * ITEM;
        @(negedge clock);
        checks++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL start_idle got st=%0d ocup=%0b exp st=0 ocup=0", db_estado, ocupado);
        end
        iniciar = 1'b1;
        limite  = lim[3:0];
        for (int k = 1; k <= kfim; k++) begin
            @(negedge clock);
            ph = (k - 1) % ITEM;
            it = (k - 1) / ITEM;
            if (k == kfim) begin
                e_st = 4'd5; e_leds = 4'd0; e_end = lim[3:0]; e_pr = 1'b1;
            end else begin
                e_st   = (ph == 0) ? 4'd1 : (ph == 1) ? 4'd2 : (ph < 2 + TA) ? 4'd3 : 4'd4;
                e_leds = (ph >= 2 && ph < 2 + TA) ? rom[it] : 4'd0;
                e_end  = it[3:0];
                e_pr   = 1'b0;
            end
            checks += 5;
            if (db_estado !== e_st) begin
                failures++;
                $display("FAIL run_state lim=%0d k=%0d got=%0d exp=%0d", lim, k, db_estado, e_st);
            end
            if (leds !== e_leds) begin
                failures++;
                $display("FAIL run_leds lim=%0d k=%0d got=%0h exp=%0h", lim, k, leds, e_leds);
            end
            if (endereco !== e_end) begin
                failures++;
                $display("FAIL run_endereco lim=%0d k=%0d got=%0d exp=%0d", lim, k, endereco, e_end);
            end
            if (pronto !== e_pr) begin
                failures++;
                $display("FAIL run_pronto lim=%0d k=%0d got=%0b exp=%0b", lim, k, pronto, e_pr);
            end
            if (ocupado !== 1'b1) begin
                failures++;
                $display("FAIL run_ocupado lim=%0d k=%0d got=%0b exp=1", lim, k, ocupado);
            end
            if (k == 1) iniciar = 1'b0;
            if (perturb && k == 12) begin iniciar = 1'b1; limite = 4'd9; end
            if (perturb && k == 13) iniciar = 1'b0;
        end
    endtask

    task automatic test_after_run(input int lim);
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (db_estado !== 4'd0 || endereco !== lim[3:0] || pronto !== 1'b0 || leds !== 4'd0) begin
                failures++;
                $display("FAIL after_run got st=%0d end=%0d pronto=%0b leds=%0h exp st=0 end=%0d pronto=0 leds=0",
                         db_estado, endereco, pronto, leds, lim);
            end
        end
    endtask

    task automatic test_single_item();
        load_rom_random();
        rom[0] = 4'b0001;
        run_sequence(0, 1'b0);
        test_after_run(0);
    endtask

    task automatic test_four_items();
        rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4; rom[3] = 4'd8;
        run_sequence(3, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Restart in the cycle right after pronto, with a mid-run disturbance.
        run_sequence(3, 1'b1);
        rom[0] = 4'd0;   // a zero value still takes its full slot
        run_sequence(2, 1'b0);
        test_after_run(2);
    endtask

    task automatic test_reset_mid();
        rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4; rom[3] = 4'd8;
        @(negedge clock);
        iniciar = 1'b1; limite = 4'd3;
        @(negedge clock);
        iniciar = 1'b0;
        // k=1 now; item 2 on-time spans k=19..22
        repeat (19) @(negedge clock);
        checks++;
        if (leds !== 4'd4 || db_estado !== 4'd3) begin
            failures++;
            $display("FAIL pre_reset got leds=%0h st=%0d exp leds=4 st=3", leds, db_estado);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (leds !== 4'd0 || endereco !== 4'd0 || db_estado !== 4'd0 || pronto !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got leds=%0h end=%0d st=%0d pronto=%0b exp all 0",
                     leds, endereco, db_estado, pronto);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if (pronto !== 1'b0 || ocupado !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_quiet i=%0d got pronto=%0b ocup=%0b exp 0 0", i, pronto, ocupado);
            end
        end
    endtask

    task automatic test_full_rom();
        load_rom_random();
        run_sequence(15, 1'b0);
        test_after_run(15);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++) begin
            load_rom_random();
            run_sequence(int'($urandom_range(0, 15)), r[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'd0;
        reset = 1'b1; iniciar = 1'b0; limite = 4'd0;
        test_reset();
        test_single_item();
        test_four_items();
        test_back_to_back();
        test_reset_mid();
        test_full_rom();
        test_random_runs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exibe_sequencia.md
# exibe_sequencia

Sequence-display engine for the memory game: on a start pulse it walks the preloaded 16x4 synchronous ROM from address 0 up to a registered round limit. It shows each stored value on the LEDs for a fixed on-time, followed by a blank gap. It is the output-side counterpart of the play-capture datapath: that path reads the player's switches and compares them against ROM, while this block presents the ROM contents to the player. The game's control unit instantiates it and waits for `pronto` before enabling play capture.

## Interface
- `TEMPO_ACESO`, default 50_000_000: cycles each item is shown on the LEDs; must be ≥1.
- `TEMPO_APAGADO`, default 25_000_000: blank cycles after each item; must be ≥1.
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iniciar`  in  1  start request; sampled only in INICIAL.
- `limite`  in  4  last ROM address to show (round number); registered at start.
- `dado_rom`  in  4  ROM data output; valid one cycle after `endereco` changes (synchronous ROM).
- `endereco`  out  4  ROM address.
- `leds`  out  4  displayed value (registered); 0 when blank.
- `ocupado`  out  1  high in every state except INICIAL.
- `pronto`  out  1  one-cycle pulse when the sequence has been fully shown.
- `db_estado`  out  4  FSM state code, for debug.

## Operation
- The FSM states and their codes are INICIAL=0, PREPARA=1, CARREGA=2, ACESO=3, APAGADO=4, FIM=5.
- INICIAL
  - If `iniciar`=1: load `limite` into `lim_r`, clear `endereco` to 0, go to PREPARA.
  - Otherwise stay in INICIAL.
- PREPARA: lasts 1 cycle and covers the ROM address-to-data latency. Next state is CARREGA.
- CARREGA: lasts 1 cycle. `leds` ← `dado_rom` on exit; clear the timer; go to ACESO.
- ACESO
  - Hold `leds`.
  - After exactly `TEMPO_ACESO` cycles in this state: `leds` ← 0, clear the timer, go to APAGADO.
- APAGADO
  - `leds`=0.
  - After exactly `TEMPO_APAGADO` cycles:
    - if `endereco`==`lim_r`, go to FIM;
    - otherwise increment `endereco` and go to PREPARA.
- FIM: `pronto`=1 for this single cycle; go to INICIAL.
- `endereco` holds its last value after FIM. It is cleared only by reset or by an accepted `iniciar`.
- The address never wraps. With `limite`=15, items 0..15 are shown and `endereco` stops at 15. With `limite`=0, exactly one item is shown.
- `iniciar` is ignored while `ocupado`=1.
- Changes on `limite` after start are ignored.
- A value of 0 stored in ROM is shown as blank LEDs but still takes the full `TEMPO_ACESO` slot.

## Timing
- Reset values: state INICIAL, `endereco`=0, `leds`=0, `ocupado`=0, `pronto`=0, `db_estado`=0, timer=0.
- Reset has priority over every other input, including `iniciar` in the same cycle.
- Reset during any state returns to INICIAL on the next edge and produces no `pronto` pulse.
- Let `iniciar` be accepted at the edge ending cycle t:
  - PREPARA at t+1, CARREGA at t+2.
  - First item on `leds` during cycles t+3 .. t+2+`TEMPO_ACESO`.
- Each item takes 2+`TEMPO_ACESO`+`TEMPO_APAGADO` cycles.
- `pronto` is high in cycle t+1+(`lim_r`+1)·(2+`TEMPO_ACESO`+`TEMPO_APAGADO`).
- A new `iniciar` is accepted no earlier than the cycle after `pronto`.
- Timer width is wide enough for max(`TEMPO_ACESO`,`TEMPO_APAGADO`) and compares against parameter−1. The timer never overflows.

## Structure
- A shared header holds the state codes as localparams. `db_estado` and the control unit's debug decoder both use them.
- One sub-module, `temporizador_exibicao`:
  - parameterised modulo-N counter with synchronous clear, enable, and a `fim` flag at N−1;
  - instantiated once, with N selected by state.
- Address counter, `lim_r`, `leds` register and the FSM are kept in the top module.

## Test plan
All scenarios use `TEMPO_ACESO`=4 and `TEMPO_APAGADO`=2, so each item takes 8 cycles, and a ROM model with 1-cycle latency.
1. Reset asserted for 2 cycles → all outputs 0, `db_estado`=0. `iniciar`=1 together with `reset`=1 → stays in INICIAL.
2. `limite`=0, ROM[0]=4'b0001, `iniciar` accepted at t:
   - `leds`=0001 during t+3..t+6 and 0 during t+7..t+8;
   - `pronto` high only at t+9;
   - `ocupado` is 1 during t+1..t+9.
3. `limite`=3, ROM=1,2,4,8 → `endereco` steps 0..3 and `leds` shows 1,2,4,8 in successive 8-cycle slots. `pronto` at t+33.
4. During the run of scenario 3:
   - pulse `iniciar` and change `limite` to 9 mid-run → no restart, `pronto` still at t+33;
   - `iniciar` in the cycle after `pronto` → accepted.
5. `reset` asserted while in ACESO on item 2 → next cycle `leds`=0, `endereco`=0, state INICIAL, no `pronto` pulse.
6. `limite`=15 → 16 items shown, `endereco` ends at 15 and does not wrap to 0. `pronto` at t+129.
